// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI message parser.
//   state_t        parser FSM states
//   status consts  MIDI status byte values (voice, system common, real-time)
//   midi_data_len  number of data bytes (0..2) that follow a status byte
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_D1,
        ST_WAIT_D2,
        ST_SYSEX
    } state_t;

    // Channel voice messages (low nibble = channel)
    localparam logic [7:0] NOTE_OFF     = 8'h80;
    localparam logic [7:0] NOTE_ON      = 8'h90;
    localparam logic [7:0] POLY_AT      = 8'hA0;
    localparam logic [7:0] CTRL_CHANGE  = 8'hB0;
    localparam logic [7:0] PROG_CHANGE  = 8'hC0;
    localparam logic [7:0] CHAN_AT      = 8'hD0;
    localparam logic [7:0] PITCH_BEND   = 8'hE0;

    // System common
    localparam logic [7:0] SYSEX        = 8'hF0;
    localparam logic [7:0] MTC_QFRAME   = 8'hF1;
    localparam logic [7:0] SONG_POS     = 8'hF2;
    localparam logic [7:0] SONG_SEL     = 8'hF3;
    localparam logic [7:0] UNDEF_F4     = 8'hF4;
    localparam logic [7:0] UNDEF_F5     = 8'hF5;
    localparam logic [7:0] TUNE_REQ     = 8'hF6;
    localparam logic [7:0] EOX          = 8'hF7;

    // System real-time
    localparam logic [7:0] CLOCK        = 8'hF8;
    localparam logic [7:0] TICK         = 8'hF9;
    localparam logic [7:0] START        = 8'hFA;
    localparam logic [7:0] CONTINUE     = 8'hFB;
    localparam logic [7:0] STOP         = 8'hFC;
    localparam logic [7:0] UNDEF_FD     = 8'hFD;
    localparam logic [7:0] ACTIVE_SENSE = 8'hFE;
    localparam logic [7:0] SYS_RESET    = 8'hFF;

    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = '0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            4'hC, 4'hD:                   len = 2'd1;
            4'hF: begin
                case (status)
                    MTC_QFRAME, SONG_SEL: len = 2'd1;
                    SONG_POS:             len = 2'd2;
                    default:              len = 2'd0;
                endcase
            end
            default:                      len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_byte_strobe.sv
// midi_byte_strobe: turns the byte detector's level-type byte_ready into a
// single-cycle strobe on its rising edge and presents the byte alongside.
//   clk, rst     clock, asynchronous active-high reset
//   byte_in      received byte, stable while byte_ready is high
//   byte_ready   level, high for many clocks per byte
//   strobe       high for exactly the accept cycle (byte_ready=1, rdy_d=0)
//   rx_byte      byte to consume when strobe is high
module midi_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_ready,
    output logic       strobe,
    output logic [7:0] rx_byte
);

    logic rdy_d;

    // Resetting to 1 makes a level already high at reset release look like
    // "no edge", so a byte in flight across reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_d <= 1'b1;
        else     rdy_d <= byte_ready;
    end

    // Combinational strobe so the parser registers its result on the same
    // edge that ends the accept cycle: msg_valid follows one clock later.
    assign strobe  = byte_ready & ~rdy_d;
    assign rx_byte = byte_in;

endmodule

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: assembles MIDI messages (status + 0..2 data bytes) from a
// byte stream, with running status, SysEx skipping and channel filtering.
//   Parameters: OMNI (1 = all channels, 0 = only CHANNEL), CHANNEL (4 bits)
//   Macro MIDI_REALTIME_EN: when defined, each real-time byte (F8-FF except
//     F9/FD) emits its own message; otherwise real-time bytes are dropped.
//   clk, rst      clock, asynchronous active-high reset
//   byte_in       received byte
//   byte_ready    level; only its rising edge accepts a byte
//   msg_valid     one-clock pulse, msg_* hold a complete message
//   msg_status    status byte
//   msg_data1/2   data bytes (0 when absent)
//   err_orphan    one-clock pulse: data byte with no running status
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_ready,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       err_orphan
);

    logic       strobe;
    logic [7:0] rx_byte;

    midi_byte_strobe u_strobe (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .strobe     (strobe),
        .rx_byte    (rx_byte)
    );

    state_t     state, state_n;
    logic [7:0] rs, rs_n;          // running status; 0 means none (bit7 = valid)
    logic [7:0] cur_st, cur_st_n;  // status of the message being assembled
    logic [6:0] d1, d1_n;

    logic       emit;
    logic [7:0] emit_st;
    logic [6:0] emit_d1, emit_d2;
    logic       orphan;
    logic       pass;
    logic       valid_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rs         <= '0;
            cur_st     <= '0;
            d1         <= '0;
            msg_valid  <= 1'b0;
            err_orphan <= 1'b0;
            msg_status <= '0;
            msg_data1  <= '0;
            msg_data2  <= '0;
        end else begin
            state      <= state_n;
            rs         <= rs_n;
            cur_st     <= cur_st_n;
            d1         <= d1_n;
            msg_valid  <= valid_n;
            err_orphan <= orphan;
            if (valid_n) begin
                msg_status <= emit_st;
                msg_data1  <= emit_d1;
                msg_data2  <= emit_d2;
            end
        end
    end

    always_comb begin
        state_n  = state;
        rs_n     = rs;
        cur_st_n = cur_st;
        d1_n     = d1;
        emit     = 1'b0;
        emit_st  = cur_st;
        emit_d1  = d1;
        emit_d2  = '0;
        orphan   = 1'b0;

        if (strobe) begin
            if (rx_byte >= CLOCK) begin
                // Real-time bytes never touch state, running status or data.
`ifdef MIDI_REALTIME_EN
                if (rx_byte != TICK && rx_byte != UNDEF_FD) begin
                    emit    = 1'b1;
                    emit_st = rx_byte;
                    emit_d1 = '0;
                    emit_d2 = '0;
                end
`else
                emit = 1'b0;
`endif
            end else if (rx_byte == EOX) begin
                if (state == ST_SYSEX) state_n = ST_IDLE;
            end else if (rx_byte[7]) begin
                if (rx_byte < SYSEX) begin
                    rs_n     = rx_byte;
                    cur_st_n = rx_byte;
                    d1_n     = '0;
                    state_n  = ST_WAIT_D1;
                end else begin
                    rs_n = '0;
                    case (rx_byte)
                        SYSEX: state_n = ST_SYSEX;
                        MTC_QFRAME, SONG_POS, SONG_SEL, TUNE_REQ: begin
                            cur_st_n = rx_byte;
                            d1_n     = '0;
                            if (midi_data_len(rx_byte) == 2'd0) begin
                                emit    = 1'b1;
                                emit_st = rx_byte;
                                emit_d1 = '0;
                                state_n = ST_IDLE;
                            end else begin
                                state_n = ST_WAIT_D1;
                            end
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end else begin
                case (state)
                    ST_WAIT_D1: begin
                        d1_n = rx_byte[6:0];
                        if (midi_data_len(cur_st) == 2'd1) begin
                            emit    = 1'b1;
                            emit_d1 = rx_byte[6:0];
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit    = 1'b1;
                        emit_d2 = rx_byte[6:0];
                        state_n = ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (rs[7]) begin
                            // Running status: this byte is d1 of a new message.
                            cur_st_n = rs;
                            d1_n     = rx_byte[6:0];
                            if (midi_data_len(rs) == 2'd1) begin
                                emit    = 1'b1;
                                emit_st = rs;
                                emit_d1 = rx_byte[6:0];
                                state_n = ST_IDLE;
                            end else begin
                                state_n = ST_WAIT_D2;
                            end
                        end else begin
                            orphan = 1'b1;
                        end
                    end
                    default: ; // SysEx payload discarded
                endcase
            end
        end

        // Only channel voice messages are subject to the channel filter.
        pass    = OMNI || (emit_st >= SYSEX) || (emit_st[3:0] == CHANNEL);
        valid_n = emit && pass;
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_ready;

    // index 0: OMNI instance, index 1: OMNI=0, CHANNEL=1
    logic       mv [2];
    logic [7:0] ms [2];
    logic [6:0] m1 [2];
    logic [6:0] m2 [2];
    logic       eo [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    midi_msg_parser dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_ready(byte_ready),
        .msg_valid(mv[0]), .msg_status(ms[0]), .msg_data1(m1[0]),
        .msg_data2(m2[0]), .err_orphan(eo[0])
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd1)) dut_f (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_ready(byte_ready),
        .msg_valid(mv[1]), .msg_status(ms[1]), .msg_data1(m1[1]),
        .msg_data2(m2[1]), .err_orphan(eo[1])
    );

    // ---------------- reference model ----------------
    int   m_rs [2];      // running status, 0 = none
    int   m_st [2];      // status of message in progress
    int   m_n  [2];      // bytes collected incl. status, 0 = nothing pending
    int   m_d  [2][3];
    bit   m_sx [2];
    logic       e_v [2];
    logic       e_o [2];
    logic [7:0] e_s [2];
    logic [6:0] e_1 [2];
    logic [6:0] e_2 [2];

    function automatic int blen(int s);
        if (s >= 'hC0 && s < 'hE0) return 1;
        if (s < 'hF0)              return 2;
        if (s == 'hF1 || s == 'hF3) return 1;
        if (s == 'hF2)             return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rs[k] = 0; m_st[k] = 0; m_n[k] = 0; m_sx[k] = 1'b0;
            e_v[k] = 1'b0; e_o[k] = 1'b0;
            e_s[k] = '0; e_1[k] = '0; e_2[k] = '0;
        end
    endtask

    task automatic model_emit(int k, int st, int a, int b);
        if (k == 1 && st < 'hF0 && (st % 16) != 1) return;
        e_v[k] = 1'b1;
        e_s[k] = 8'(st);
        e_1[k] = 7'(a);
        e_2[k] = 7'(b);
    endtask

    task automatic model_byte(int k, int b);
        if (b >= 'hF8) begin
`ifdef MIDI_REALTIME_EN
            if (b != 'hF9 && b != 'hFD) model_emit(k, b, 0, 0);
`endif
            return;
        end
        if (b == 'hF7) begin
            if (m_sx[k]) begin m_sx[k] = 1'b0; m_n[k] = 0; end
            return;
        end
        if (b >= 'h80) begin
            m_sx[k] = 1'b0;
            if (b < 'hF0) begin
                m_rs[k] = b; m_st[k] = b; m_n[k] = 1;
            end else if (b == 'hF0) begin
                m_rs[k] = 0; m_n[k] = 0; m_sx[k] = 1'b1;
            end else if (b == 'hF4 || b == 'hF5) begin
                m_rs[k] = 0; m_n[k] = 0;
            end else begin
                m_rs[k] = 0; m_st[k] = b; m_n[k] = 1;
                if (blen(b) == 0) begin model_emit(k, b, 0, 0); m_n[k] = 0; end
            end
            return;
        end
        if (m_sx[k]) return;
        if (m_n[k] > 0) begin
            m_d[k][m_n[k]] = b;
            m_n[k]++;
            if (m_n[k] == 1 + blen(m_st[k])) begin
                model_emit(k, m_st[k], m_d[k][1], (blen(m_st[k]) == 2) ? m_d[k][2] : 0);
                m_n[k] = 0;
            end
        end else if (m_rs[k] != 0) begin
            m_st[k] = m_rs[k]; m_d[k][1] = b; m_n[k] = 2;
            if (blen(m_st[k]) == 1) begin model_emit(k, m_st[k], b, 0); m_n[k] = 0; end
        end else begin
            e_o[k] = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid[%0d]", k),  32'(mv[k]), 32'(e_v[k]));
            check($sformatf("orphan[%0d]", k), 32'(eo[k]), 32'(e_o[k]));
            check($sformatf("status[%0d]", k), 32'(ms[k]), 32'(e_s[k]));
            check($sformatf("data1[%0d]", k),  32'(m1[k]), 32'(e_1[k]));
            check($sformatf("data2[%0d]", k),  32'(m2[k]), 32'(e_2[k]));
            e_v[k] = 1'b0;
            e_o[k] = 1'b0;
        end
    endtask

    // Called at a negedge with byte_ready low for at least one posedge.
    task automatic send(logic [7:0] b, int hold);
        byte_in    = b;
        byte_ready = 1'b1;
        model_byte(0, int'(b));
        model_byte(1, int'(b));
        repeat (hold) begin
            @(negedge clk);
            check_all();
        end
        byte_ready = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic send_seq(logic [7:0] seq [$]);
        foreach (seq[i]) send(seq[i], 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] sys [8];
        sys = '{8'hF0, 8'hF7, 8'hF1, 8'hF2, 8'hF3, 8'hF6, 8'hF4, 8'hF5};
        r = int'($urandom_range(0, 99));
        if (r < 50) return {1'b0, 7'($urandom)};
        if (r < 80) return {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
        if (r < 90) return sys[$urandom_range(0, 7)];
        return 8'hF8 + 8'($urandom_range(0, 7));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        byte_in    = '0;
        byte_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // 1: simple note-on, plus constant expectations
        send_seq('{8'h90, 8'h3C, 8'h64});
        check("t1_status", 32'(ms[0]), 32'h90);
        check("t1_data1",  32'(m1[0]), 32'h3C);
        check("t1_data2",  32'(m2[0]), 32'h64);

        // 2: running status
        send_seq('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00});
        check("t2_data1", 32'(m1[0]), 32'h3E);
        check("t2_data2", 32'(m2[0]), 32'h00);

        // 3: one-byte message, tune request, orphan
        send_seq('{8'hC5, 8'h07, 8'hF6, 8'h3C});

        // 4: real-time inside a message
        send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64});

        // 5: SysEx skip, abandoned partial message
        send_seq('{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C, 8'h90, 8'h3C, 8'h80, 8'h40, 8'h00});
        check("t5_status", 32'(ms[0]), 32'h80);

        // 6: channel filter, reset mid-message, long level
        send_seq('{8'h90, 8'h3C, 8'h64, 8'h91, 8'h3C, 8'h64});
        check("t6_filt_status", 32'(ms[1]), 32'h91);
        send_seq('{8'h91, 8'h3C});
        do_reset();
        send(8'h64, 1);
        send(8'h91, 800);
        send(8'h3C, 3);
        send(8'h64, 800);

        // byte in flight across reset release is dropped
        rst        = 1'b1;
        byte_in    = 8'h90;
        byte_ready = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        byte_ready = 1'b0;
        @(negedge clk);
        check_all();
        send(8'h3C, 1);

        // randomized stream, including back-to-back accepts every 2 clocks
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            send(rand_byte(), int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_all();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
